mem_slot_sched: RTL and testbench
=================================

# mem_slot_sched

Scheduler for the SDRAM port A slot: on every NES slot boundary it decides whether the CPU, the ROM loader or the battery-RAM backup engine owns the port for the next slot. It replaces the ad-hoc loader-write latch and address/data muxing between data_io/GameLoader, the NES core and the sdram controller. It also pauses the NES CPU around backup sessions with a request/acknowledge handshake.

## Interface
- ADDR_W, 22, byte address width on every port
- RD_PHASE, 2'd0, nes_ce phase at which SDRAM read data is valid and captured for the backup requester
- clk  in  1  system clock (the same as the NES core)
- reset  in  1  synchronous, active-high
- nes_ce  in  2  slot phase counter 0..3; a slot boundary is any clk where nes_ce==1
- downloading  in  1  ROM download in progress (data_io)
- ld_wr  in  1  one-clk strobe: loader byte ready
- ld_addr  in  ADDR_W  loader address
- ld_data  in  8  loader data
- ld_overrun  out  1  sticky: an ld_wr arrived while the previous byte was still pending; cleared by reset
- bk_session  in  1  level: backup engine wants exclusive access
- bk_req  in  1  level: backup access request, held until bk_ack
- bk_we  in  1  1 = write, 0 = read
- bk_addr  in  ADDR_W  backup address
- bk_din  in  8  backup write data
- bk_ack  out  1  one-clk pulse: access done; for reads, bk_dout is valid in the same clk
- bk_dout  out  8  read data, held until the next ack
- cpu_addr  in  ADDR_W; cpu_rd  in  1; cpu_wr  in  1; cpu_dout  in  8: NES core CPU memory request
- cpu_din  out  8  pass-through of mem_din
- cpu_pause  out  1  request to the NES core to freeze the CPU
- cpu_paused  in  1  NES core acknowledge: CPU frozen, no further cpu_rd/cpu_wr
- mem_addr  out  ADDR_W; mem_rd  out  1; mem_wr  out  1; mem_dout  out  8: to sdram port A
- mem_din  in  8  from sdram port A
- owner  out  2  0 = CPU, 1 = LOADER, 2 = BACKUP, 3 = transition (PAUSING/RESUMING)

## Operation
- FSM states: CPU, LOADER, PAUSING, BACKUP, RESUMING. Reset sends the FSM to CPU.
- Reset values: owner=0, cpu_pause=0, mem_rd=mem_wr=0, mem_addr=0, mem_dout=0, bk_ack=0, bk_dout=0, ld_overrun=0, loader pending flag=0.
- State transitions are evaluated only at slot boundaries. downloading has the highest priority.
  - CPU -> LOADER when downloading=1.
  - CPU -> PAUSING when bk_session=1 and downloading=0.
- LOADER: an ld_wr on any clk latches ld_addr/ld_data and sets the pending flag.
  - At a boundary with pending=1: mem_wr=1 with the latched address and data for that slot (4 clk), then pending clears.
  - At most one loader write per slot.
  - LOADER -> CPU at the first boundary with downloading=0 and pending=0. The last byte is never dropped.
- PAUSING: cpu_pause=1 from entry. Advance to BACKUP at the first boundary with cpu_paused=1. If bk_session drops first, go to RESUMING.
- BACKUP: at a boundary with bk_req=1 and no access outstanding, issue one access for the slot.
  - Write: bk_ack pulses at the next boundary.
  - Read: mem_din is captured into bk_dout at the first nes_ce==RD_PHASE after issue, with bk_ack in the same clk.
  - BACKUP -> RESUMING at a boundary with bk_session=0 and no access outstanding.
  - If downloading rises during BACKUP, finish the outstanding access, then go to RESUMING. LOADER is then entered from CPU.
- RESUMING: cpu_pause=0. Go to CPU at the first boundary with cpu_paused=0.
- CPU state: mem_* is combinationally equal to cpu_addr/cpu_rd/cpu_wr/cpu_dout. The CPU path adds no latency.
- Overrun: ld_wr while pending=1 overwrites the latch and sets ld_overrun.
- ld_wr outside LOADER is latched and sets pending, but no write is issued until LOADER is entered.

## Timing
- A slot is 4 clk. Non-CPU mem_rd/mem_wr/mem_addr are registered and change only on the clk after a boundary. They are held for the whole slot.
- Loader latency: from ld_wr to mem_wr is 1..5 clk, depending on phase.
- Sustained loader rate: 1 byte per 4 clk.
- Backup write: bk_ack arrives 4 clk after the issue boundary.
- Backup read: bk_ack arrives at issue + distance to RD_PHASE; the capture is never in the issue clk itself.
- cpu_pause to CPU-freeze: unbounded. Only an owner change gated by cpu_paused may grant BACKUP.
- Reset mid-operation: all outputs go to their reset values on the next clk. Any outstanding access is abandoned and gets no ack.

## Test plan
- Download of 3 bytes at addr 0x000010..12, spaced 8 clk apart -> exactly three mem_wr slots with matching data; owner returns to 0 after downloading falls; ld_overrun=0.
- Two ld_wr 1 clk apart -> ld_overrun=1; the second byte is written; one mem_wr slot only.
- downloading falls while a byte is pending -> the byte is still written before owner=0.
- Backup session: bk_session=1, cpu_paused rises 10 clk later -> owner=2 only after cpu_paused.
  - Then write 0xA5 @0x3F0000 -> one mem_wr slot, followed by bk_ack.
  - Then read the same address with the memory model returning 0xA5 -> bk_dout=0xA5 at RD_PHASE.
- bk_session falls -> cpu_pause=0; owner=0 once cpu_paused=0; CPU pass-through resumes with zero latency.
- Reset asserted during a backup read -> next clk: owner=0, cpu_pause=0, mem_rd=0, and no bk_ack afterwards.

Source files
------------

// File: rtl/mem_slot_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_slot_sched
// Purpose  : Per-slot owner arbitration of SDRAM port A between the NES CPU,
//            the ROM loader and the battery-RAM backup engine.
// Revision : 1.0 - initial release
// ============================================================================
module mem_slot_sched #(
    parameter int         ADDR_W   = 22,
    parameter logic [1:0] RD_PHASE = 2'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        nes_ce,
    input  logic              downloading,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_overrun,
    input  logic              bk_session,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [ADDR_W-1:0] bk_addr,
    input  logic [7:0]        bk_din,
    output logic              bk_ack,
    output logic [7:0]        bk_dout,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    output logic              cpu_pause,
    input  logic              cpu_paused,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    output logic [1:0]        owner
);

    localparam logic [2:0] c_ST_CPU      = 3'd0;
    localparam logic [2:0] c_ST_LOADER   = 3'd1;
    localparam logic [2:0] c_ST_PAUSING  = 3'd2;
    localparam logic [2:0] c_ST_BACKUP   = 3'd3;
    localparam logic [2:0] c_ST_RESUMING = 3'd4;

    localparam logic [1:0] c_OWN_CPU    = 2'd0;
    localparam logic [1:0] c_OWN_LOADER = 2'd1;
    localparam logic [1:0] c_OWN_BACKUP = 2'd2;
    localparam logic [1:0] c_OWN_TRANS  = 2'd3;

    logic [2:0]        r_state;
    logic [1:0]        r_owner;
    logic              r_cpu_pause;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [7:0]        r_mem_dout;
    logic              r_pend;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [7:0]        r_ld_data;
    logic              r_overrun;
    logic              r_bk_out;
    logic              r_bk_rd;
    logic [7:0]        r_bk_dout;

    logic w_bnd;
    logic w_consume;
    logic w_bk_done;

    assign w_bnd     = (nes_ce == 2'd1);
    assign w_consume = (r_state == c_ST_LOADER) && w_bnd && r_pend;
    // Writes complete at the end of their slot, reads at the data-valid phase.
    assign w_bk_done = r_bk_out && (r_bk_rd ? (nes_ce == RD_PHASE) : w_bnd);

    assign bk_ack     = w_bk_done && !reset;
    assign bk_dout    = (bk_ack && r_bk_rd) ? mem_din : r_bk_dout;
    assign ld_overrun = r_overrun;
    assign cpu_pause  = r_cpu_pause;
    assign owner      = r_owner;
    assign cpu_din    = mem_din;

    always_comb begin
        if (r_state == c_ST_CPU) begin
            mem_addr = cpu_addr;
            mem_rd   = cpu_rd;
            mem_wr   = cpu_wr;
            mem_dout = cpu_dout;
        end else begin
            mem_addr = r_mem_addr;
            mem_rd   = r_mem_rd;
            mem_wr   = r_mem_wr;
            mem_dout = r_mem_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_CPU;
            r_owner     <= c_OWN_CPU;
            r_cpu_pause <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_dout  <= 8'h00;
            r_pend      <= 1'b0;
            r_ld_addr   <= '0;
            r_ld_data   <= 8'h00;
            r_overrun   <= 1'b0;
            r_bk_out    <= 1'b0;
            r_bk_rd     <= 1'b0;
            r_bk_dout   <= 8'h00;
        end else begin
            if (ld_wr) begin
                r_ld_addr <= ld_addr;
                r_ld_data <= ld_data;
                r_pend    <= 1'b1;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end
            // A byte handed to memory on this very clk frees the latch in time.
            if (ld_wr && r_pend && !w_consume)
                r_overrun <= 1'b1;

            if (w_bk_done) begin
                r_bk_out <= 1'b0;
                if (r_bk_rd)
                    r_bk_dout <= mem_din;
            end

            if (w_bnd) begin
                r_mem_rd <= 1'b0;
                r_mem_wr <= 1'b0;
                case (r_state)
                    c_ST_CPU: begin
                        if (downloading) begin
                            r_state <= c_ST_LOADER;
                            r_owner <= c_OWN_LOADER;
                        end else if (bk_session) begin
                            r_state     <= c_ST_PAUSING;
                            r_owner     <= c_OWN_TRANS;
                            r_cpu_pause <= 1'b1;
                        end
                    end
                    c_ST_LOADER: begin
                        if (r_pend) begin
                            r_mem_wr   <= 1'b1;
                            r_mem_addr <= r_ld_addr;
                            r_mem_dout <= r_ld_data;
                        end else if (!downloading) begin
                            r_state <= c_ST_CPU;
                            r_owner <= c_OWN_CPU;
                        end
                    end
                    c_ST_PAUSING: begin
                        if (downloading || !bk_session) begin
                            r_state     <= c_ST_RESUMING;
                            r_cpu_pause <= 1'b0;
                        end else if (cpu_paused) begin
                            r_state <= c_ST_BACKUP;
                            r_owner <= c_OWN_BACKUP;
                        end
                    end
                    c_ST_BACKUP: begin
                        if (!r_bk_out && (downloading || !bk_session)) begin
                            r_state     <= c_ST_RESUMING;
                            r_owner     <= c_OWN_TRANS;
                            r_cpu_pause <= 1'b0;
                        end else if (!r_bk_out && bk_req) begin
                            r_mem_rd   <= !bk_we;
                            r_mem_wr   <= bk_we;
                            r_mem_addr <= bk_addr;
                            r_mem_dout <= bk_din;
                            r_bk_out   <= 1'b1;
                            r_bk_rd    <= !bk_we;
                        end
                    end
                    c_ST_RESUMING: begin
                        if (!cpu_paused) begin
                            r_state <= c_ST_CPU;
                            r_owner <= c_OWN_CPU;
                        end
                    end
                    default: begin
                        r_state <= c_ST_CPU;
                        r_owner <= c_OWN_CPU;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_slot_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_slot_sched
// Purpose  : Directed self-checking bench for mem_slot_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_slot_sched;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    nes_ce = 2'd0;
    logic          downloading = 1'b0;
    logic          ld_wr = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_overrun;
    logic          bk_session = 1'b0;
    logic          bk_req = 1'b0;
    logic          bk_we = 1'b0;
    logic [AW-1:0] bk_addr = '0;
    logic [7:0]    bk_din = 8'h00;
    logic          bk_ack;
    logic [7:0]    bk_dout;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [7:0]    cpu_dout = 8'h00;
    logic [7:0]    cpu_din;
    logic          cpu_pause;
    logic          cpu_paused = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_dout;
    logic [7:0]    mem_din;
    logic [1:0]    owner;

    mem_slot_sched #(.ADDR_W(AW), .RD_PHASE(2'd0)) dut (
        .clk(clk), .reset(reset), .nes_ce(nes_ce), .downloading(downloading),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_overrun(ld_overrun),
        .bk_session(bk_session), .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr),
        .bk_din(bk_din), .bk_ack(bk_ack), .bk_dout(bk_dout),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_pause(cpu_pause), .cpu_paused(cpu_paused),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
        .mem_din(mem_din), .owner(owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) nes_ce <= nes_ce + 2'd1;

    // One-entry memory model plus a log of completed write slots.
    logic [AW-1:0]   lw_addr = '0;
    logic [7:0]      lw_data = 8'h00;
    logic [AW+7:0]   wq[$];

    always @(posedge clk) begin
        if (!reset && mem_wr && nes_ce == 2'd1) begin
            wq.push_back({mem_addr, mem_dout});
            lw_addr <= mem_addr;
            lw_data <= mem_dout;
        end
    end
    assign mem_din = (mem_rd && mem_addr == lw_addr) ? lw_data : 8'h00;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input int idx);
        if (idx < wq.size()) return 32'(wq[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_owner(input logic [1:0] exp, input int max_clk, input string tag);
        for (int i = 0; i < max_clk && owner !== exp; i++) @(negedge clk);
        check_val(tag, 32'(owner), 32'(exp));
    endtask

    task automatic wait_phase(input logic [1:0] p);
        for (int i = 0; i < 4 && nes_ce !== p; i++) @(negedge clk);
    endtask

    task automatic ld_byte(input logic [AW-1:0] a, input logic [7:0] d, input string tag);
        int lat;
        lat = 0;
        ld_addr = a;
        ld_data = d;
        ld_wr   = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) ld_wr = 1'b0;
            if (lat == 0 && mem_wr === 1'b1 && mem_addr === a) lat = i;
        end
        check_val(tag, 32'(lat >= 1 && lat <= 5), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack_seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_owner", 32'(owner), 32'd0);
        check_val("rst_pause", 32'(cpu_pause), 32'd0);
        check_val("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_bk_ack", 32'(bk_ack), 32'd0);
        check_val("rst_bk_dout", 32'(bk_dout), 32'd0);
        check_val("rst_overrun", 32'(ld_overrun), 32'd0);

        // Three spaced loader bytes.
        downloading = 1'b1;
        wait_owner(2'd1, 8, "ld_enter");
        ld_byte(22'h000010, 8'h11, "ld_lat0");
        ld_byte(22'h000011, 8'h22, "ld_lat1");
        ld_byte(22'h000012, 8'h33, "ld_lat2");
        downloading = 1'b0;
        wait_owner(2'd0, 12, "ld_exit");
        check_val("ld_nwr", 32'(wq.size()), 32'd3);
        check_val("ld_q0", q_at(0), {2'b0, 22'h000010, 8'h11});
        check_val("ld_q1", q_at(1), {2'b0, 22'h000011, 8'h22});
        check_val("ld_q2", q_at(2), {2'b0, 22'h000012, 8'h33});
        check_val("ld_no_ovr", 32'(ld_overrun), 32'd0);

        // Back-to-back strobes: second byte wins, one write slot.
        wq.delete();
        downloading = 1'b1;
        wait_owner(2'd1, 8, "ovr_enter");
        wait_phase(2'd2);
        ld_addr = 22'h000020; ld_data = 8'h44; ld_wr = 1'b1;
        @(negedge clk);
        ld_addr = 22'h000021; ld_data = 8'h55;
        @(negedge clk);
        ld_wr = 1'b0;
        repeat (10) @(negedge clk);
        downloading = 1'b0;
        wait_owner(2'd0, 12, "ovr_exit");
        check_val("ovr_flag", 32'(ld_overrun), 32'd1);
        check_val("ovr_nwr", 32'(wq.size()), 32'd1);
        check_val("ovr_q0", q_at(0), {2'b0, 22'h000021, 8'h55});
        reset = 1'b1;
        @(negedge clk);
        check_val("ovr_rst_clr", 32'(ld_overrun), 32'd0);
        reset = 1'b0;

        // downloading drops while a byte is still pending.
        wq.delete();
        downloading = 1'b1;
        wait_owner(2'd1, 8, "tail_enter");
        wait_phase(2'd2);
        ld_addr = 22'h000030; ld_data = 8'h66; ld_wr = 1'b1;
        @(negedge clk);
        ld_wr = 1'b0;
        downloading = 1'b0;
        wait_owner(2'd0, 16, "tail_exit");
        check_val("tail_nwr", 32'(wq.size()), 32'd1);
        check_val("tail_q0", q_at(0), {2'b0, 22'h000030, 8'h66});

        // Backup session: grant only after the CPU is frozen.
        wq.delete();
        bk_session = 1'b1;
        for (int i = 0; i < 8 && cpu_pause !== 1'b1; i++) @(negedge clk);
        check_val("bk_pause", 32'(cpu_pause), 32'd1);
        check_val("bk_own_pausing", 32'(owner), 32'd3);
        repeat (10) @(negedge clk);
        check_val("bk_no_grant", 32'(owner), 32'd3);
        cpu_paused = 1'b1;
        wait_owner(2'd2, 8, "bk_grant");

        bk_we = 1'b1; bk_addr = 22'h3F0000; bk_din = 8'hA5; bk_req = 1'b1;
        for (int i = 0; i < 12 && bk_ack !== 1'b1; i++) @(negedge clk);
        check_val("bkw_ack", 32'(bk_ack), 32'd1);
        check_val("bkw_ack_phase", 32'(nes_ce), 32'd1);
        bk_req = 1'b0;
        @(negedge clk);
        check_val("bkw_nwr", 32'(wq.size()), 32'd1);
        check_val("bkw_q0", q_at(0), {2'b0, 22'h3F0000, 8'hA5});

        bk_we = 1'b0; bk_req = 1'b1;
        for (int i = 0; i < 12 && bk_ack !== 1'b1; i++) @(negedge clk);
        check_val("bkr_ack", 32'(bk_ack), 32'd1);
        check_val("bkr_ack_phase", 32'(nes_ce), 32'd0);
        check_val("bkr_dout", 32'(bk_dout), 32'hA5);
        bk_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("bkr_hold", 32'(bk_dout), 32'hA5);
        check_val("bkr_nwr", 32'(wq.size()), 32'd1);

        // End of session and CPU pass-through.
        bk_session = 1'b0;
        for (int i = 0; i < 8 && cpu_pause !== 1'b0; i++) @(negedge clk);
        check_val("res_unpause", 32'(cpu_pause), 32'd0);
        check_val("res_own", 32'(owner), 32'd3);
        repeat (8) @(negedge clk);
        check_val("res_wait", 32'(owner), 32'd3);
        cpu_paused = 1'b0;
        wait_owner(2'd0, 8, "res_cpu");
        cpu_addr = 22'h3F0000; cpu_rd = 1'b1; cpu_dout = 8'h5A;
        #1;
        check_val("pt_addr", 32'(mem_addr), 32'h3F0000);
        check_val("pt_rd", 32'(mem_rd), 32'd1);
        check_val("pt_din", 32'(cpu_din), 32'hA5);
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 22'h000123;
        #1;
        check_val("pt_wr", 32'(mem_wr), 32'd1);
        check_val("pt_dout", 32'(mem_dout), 32'h5A);
        cpu_wr = 1'b0;
        @(negedge clk);

        // Reset in the middle of a backup read.
        bk_session = 1'b1;
        cpu_paused = 1'b1;
        wait_owner(2'd2, 16, "rr_grant");
        bk_we = 1'b0; bk_addr = 22'h3F0000; bk_req = 1'b1;
        for (int i = 0; i < 12 && mem_rd !== 1'b1; i++) @(negedge clk);
        check_val("rr_issue", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("rr_owner", 32'(owner), 32'd0);
        check_val("rr_pause", 32'(cpu_pause), 32'd0);
        check_val("rr_mem_rd", 32'(mem_rd), 32'd0);
        reset = 1'b0;
        bk_req = 1'b0; bk_session = 1'b0; cpu_paused = 1'b0;
        ack_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bk_ack === 1'b1) ack_seen = 1'b1;
            @(negedge clk);
        end
        check_val("rr_no_ack", 32'(ack_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
